pod_stripe_sensor: RTL and testbench

Emulates the pod's optical tube-stripe sensor for hardware-in-the-loop runs. It sits directly downstream of the pod kinematic model and consumes that model's 64-bit position, in nanometres. When the simulated pod crosses each reflective tube stripe, it drives a digital pulse to the flight computer under test. It also keeps a ground-truth count of stripes crossed for the HIL host.

---
 rtl/pod_stripe_sensor.sv | 133 +++++++++++++
 tb/tb_pod_stripe_sensor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pod_stripe_sensor.sv
// Optical tube-stripe sensor emulator: qualifies the kinematic model's position and
// pulses stripe_out per stripe crossed. Optional miss-fault injection via STRIPE_MISS_EN.
`timescale 1ns/1ps

module pod_stripe_sensor #(
  parameter logic [63:0] STRIPE_FIRST  = 64'd30480000000,
  parameter logic [63:0] STRIPE_PITCH  = 64'd30480000000,
  parameter logic [63:0] STRIPE_WIDTH  = 64'd101600000,
  parameter int unsigned STRIPE_COUNT  = 40,
  parameter int unsigned MIN_PULSE_CYC = 500
) (
  input  logic        clk_50Mhz,
  input  logic        rst_n,
  input  logic        running,
  input  logic [63:0] position,
`ifdef STRIPE_MISS_EN
  input  logic        miss_next,
`endif
  output logic        stripe_out,
  output logic [7:0]  stripe_count,
  output logic        past_end
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    ON,
    HOLD,
    DONE
  } state_e;

  localparam logic [15:0] PULSE_LAST = 16'(MIN_PULSE_CYC - 1);
  localparam logic [7:0]  COUNT_LAST = 8'(STRIPE_COUNT);

  state_e      state_q, state_d;
  logic [63:0] p0_q;
  logic [63:0] pos_s_q;
  logic [63:0] next_lo_q, next_lo_d;
  logic [63:0] next_hi;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic [7:0]  count_q, count_d;
  logic        miss_q, miss_d;
  logic        miss_req;
  logic        hold_exit;

`ifdef STRIPE_MISS_EN
  assign miss_req = miss_next;
`else
  assign miss_req = 1'b0;
`endif

  // Position only counts once two consecutive samples agree, so a torn
  // cross-domain update can never trip a stripe threshold.
  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      p0_q    <= '0;
      pos_s_q <= '0;
    end else begin
      p0_q <= position;
      if (position == p0_q) begin
        pos_s_q <= p0_q;
      end
    end
  end

  assign next_hi   = next_lo_q + STRIPE_WIDTH;
  assign hold_exit = (state_q == HOLD) && (pulse_cnt_q >= PULSE_LAST);

  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_lo_q   <= STRIPE_FIRST;
      pulse_cnt_q <= '0;
      count_q     <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_lo_q   <= next_lo_d;
      pulse_cnt_q <= pulse_cnt_d;
      count_q     <= count_d;
      miss_q      <= miss_d;
    end
  end

  // A stripe that is jumped over entirely still goes SEEK -> ON -> HOLD, so
  // every stripe yields exactly one minimum-width pulse.
  always_comb begin
    state_d = state_q;
    if (running) begin
      unique case (state_q)
        IDLE: state_d = SEEK;
        SEEK: if (pos_s_q >= next_lo_q) state_d = ON;
        ON:   if (pos_s_q >= next_hi) state_d = HOLD;
        HOLD: begin
          if (hold_exit) begin
            state_d = ((count_q + 8'd1) == COUNT_LAST) ? DONE : SEEK;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    count_d     = count_q;
    next_lo_d   = next_lo_q;
    miss_d      = miss_q;
    if (running && (state_q != IDLE)) begin
      if ((state_q == SEEK) && (state_d == ON)) begin
        pulse_cnt_d = '0;
      end else if (((state_q == ON) || (state_q == HOLD)) && (pulse_cnt_q != 16'hFFFF)) begin
        pulse_cnt_d = pulse_cnt_q + 16'd1;
      end
      if ((state_q == SEEK) && miss_req) begin
        miss_d = 1'b1;
      end
      if (hold_exit) begin
        count_d   = count_q + 8'd1;
        next_lo_d = next_lo_q + STRIPE_PITCH;
        miss_d    = 1'b0;
      end
    end
  end

  always_comb begin
    stripe_out   = ((state_q == ON) || (state_q == HOLD)) && !miss_q;
    past_end     = (state_q == DONE);
    stripe_count = count_q;
  end

endmodule

// File: tb/tb_pod_stripe_sensor.sv
// Self-checking bench for pod_stripe_sensor: directed vector table, multi-cycle
// corner sequences, and randomized runs against a stripe-index reference model.
`timescale 1ns/1ps

module tb_pod_stripe_sensor;

  localparam int          NSTRIPES = 3;
  localparam int          MINP     = 500;
  localparam logic [63:0] FIRST    = 64'd30480000000;
  localparam logic [63:0] PITCH    = 64'd30480000000;
  localparam logic [63:0] WIDTH    = 64'd101600000;

  logic        clk_50Mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        running   = 1'b0;
  logic [63:0] position  = '0;
`ifdef STRIPE_MISS_EN
  logic        miss_next = 1'b0;
`endif
  logic        stripe_out;
  logic [7:0]  stripe_count;
  logic        past_end;

  int errors = 0;
  int checks = 0;

  pod_stripe_sensor #(
    .STRIPE_FIRST (FIRST),
    .STRIPE_PITCH (PITCH),
    .STRIPE_WIDTH (WIDTH),
    .STRIPE_COUNT (NSTRIPES),
    .MIN_PULSE_CYC(MINP)
  ) dut (
    .clk_50Mhz   (clk_50Mhz),
    .rst_n       (rst_n),
    .running     (running),
    .position    (position),
`ifdef STRIPE_MISS_EN
    .miss_next   (miss_next),
`endif
    .stripe_out  (stripe_out),
    .stripe_count(stripe_count),
    .past_end    (past_end)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: stripe k spans [FIRST+k*PITCH, +WIDTH); mAge is the number
  // of live cycles the current pulse has been high (-1 while looking for a stripe).
  logic [63:0] mP0, mPos;
  bit          mActive, mDone, mCrossed, mMiss;
  int          mAge, mIdx;

  function automatic logic [63:0] loOf(input int k);
    return FIRST + PITCH * 64'(k);
  endfunction

  task automatic modelStep();
    logic [63:0] q;
    logic        missIn;
`ifdef STRIPE_MISS_EN
    missIn = miss_next;
`else
    missIn = 1'b0;
`endif
    if (!rst_n) begin
      mP0 = '0; mPos = '0; mActive = 0; mDone = 0;
      mCrossed = 0; mMiss = 0; mAge = -1; mIdx = 0;
    end else begin
      q = mPos;
      if (!mActive) begin
        if (running) mActive = 1;
      end else if (running && !mDone) begin
        if (mAge < 0) begin
          if (missIn) mMiss = 1;
          if (q >= loOf(mIdx)) begin
            mAge = 0;
            mCrossed = 0;
          end
        end else if (!mCrossed) begin
          if (q >= loOf(mIdx) + WIDTH) mCrossed = 1;
          mAge++;
        end else if (mAge >= MINP - 1) begin
          mIdx++;
          mAge = -1;
          mMiss = 0;
          if (mIdx == NSTRIPES) mDone = 1;
        end else begin
          mAge++;
        end
      end
      if (position == mP0) mPos = mP0;
      mP0 = position;
    end
  endtask

  task automatic tick();
    @(posedge clk_50Mhz);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic run, input logic [63:0] pos);
    rst_n    = r;
    running  = run;
    position = pos;
  endtask

  task automatic checkOutput(input string name, input logic eOut, input logic [7:0] eCnt,
                             input logic eEnd);
    checks++;
    if (stripe_out !== eOut || stripe_count !== eCnt || past_end !== eEnd) begin
      errors++;
      $display("[TB] FAIL %s: got out=%0b count=%0d end=%0b, expected out=%0b count=%0d end=%0b",
               name, stripe_out, stripe_count, past_end, eOut, eCnt, eEnd);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, (mAge >= 0) && !mMiss && !mDone, 8'(mIdx), mDone);
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitRise(input int bound, output int waited, output bit seen);
    seen   = 0;
    waited = bound;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (stripe_out) begin
        waited = i;
        seen   = 1;
        break;
      end
    end
  endtask

  task automatic countHigh(input int start, input int bound, output int width);
    width = start;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!stripe_out) break;
      width++;
    end
  endtask

  task automatic countLow(input int bound, output int width);
    width = 1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (stripe_out) break;
      width++;
    end
  endtask

  task automatic doReset(input logic [63:0] pos);
    applyStimulus(1'b0, 1'b0, pos);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, pos);
    for (int i = 0; i < 3; i++) tick();
  endtask

  typedef struct {
    logic        rstN;
    logic        run;
    logic [63:0] pos;
    logic        expOut;
    logic [7:0]  expCnt;
    logic        expEnd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int  w, gap;
    bit  seen, flag;
    logic [63:0] tornVals[4];
    logic [63:0] basePos;
    bit          tornPending;
    int          offLeft, r;

    vecs[0] = '{1'b0, 1'b0, 64'd15240000000, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 64'd15240000000, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 64'd15240000000, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 64'd30479999999, 1'b0, 8'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 64'd30479999999, 1'b0, 8'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'd30480000000, 1'b0, 8'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 64'd30480000000, 1'b0, 8'd0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 64'd30480000000, 1'b1, 8'd0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 64'd30480000000, 1'b1, 8'd0, 1'b0};

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].run, vecs[i].pos);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expCnt, vecs[i].expEnd);
    end

    $display("[TB] normal crossing");
    applyStimulus(1'b1, 1'b1, 64'd30581600000);
    countHigh(2, 2000, w);
    checkValue("pulse0 width", w, 500);
    checkOutput("after pulse0", 1'b0, 8'd1, 1'b0);

    $display("[TB] jump over stripe");
    doReset(64'd15240000000);
    applyStimulus(1'b1, 1'b1, 64'd61100000000);
    waitRise(20, w, seen);
    checkValue("jump latency", w, 3);
    countHigh(1, 2000, w);
    checkValue("jump pulse A width", w, 500);
    countLow(50, gap);
    checkValue("jump gap", gap, 1);
    countHigh(1, 2000, w);
    checkValue("jump pulse B width", w, 500);
    checkOutput("after jump", 1'b0, 8'd2, 1'b0);

    $display("[TB] final stripe and end");
    applyStimulus(1'b1, 1'b1, 64'd91600000000);
    waitRise(20, w, seen);
    checkValue("last latency", w, 3);
    countHigh(1, 2000, w);
    checkValue("last pulse width", w, 500);
    checkOutput("end edge", 1'b0, 8'd3, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'd200000000000);
    waitRise(30, w, seen);
    checkValue("no pulse past end", int'(seen), 0);
    checkOutput("still ended", 1'b0, 8'd3, 1'b1);

    $display("[TB] torn update");
    doReset(64'd20000000000);
    tick();
    checkOutput("torn idle", 1'b0, 8'd0, 1'b0);
    tornVals[0] = 64'd30500000000;
    tornVals[1] = 64'd30600000000;
    tornVals[2] = 64'd30700000000;
    tornVals[3] = 64'd30800000000;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, tornVals[i]);
      tick();
      checkOutput($sformatf("torn%0d", i), 1'b0, 8'd0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 64'd30900000000);
    tick();
    checkOutput("stable edge1", 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("stable edge2", 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("stable edge3", 1'b1, 8'd0, 1'b0);

    $display("[TB] freeze mid-pulse");
    for (int i = 0; i < 99; i++) tick();
    applyStimulus(1'b1, 1'b0, 64'd30900000000);
    flag = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!stripe_out) flag = 0;
    end
    checkValue("freeze holds high", int'(flag), 1);
    applyStimulus(1'b1, 1'b1, 64'd30900000000);
    countHigh(1100, 3000, w);
    checkValue("frozen pulse width", w, 1500);
    checkOutput("after freeze", 1'b0, 8'd1, 1'b0);

`ifdef STRIPE_MISS_EN
    $display("[TB] missed detection");
    doReset(64'd20000000000);
    miss_next = 1'b1;
    tick();
    miss_next = 1'b0;
    applyStimulus(1'b1, 1'b1, 64'd30700000000);
    flag = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (stripe_out) flag = 1;
    end
    checkValue("miss keeps low", int'(flag), 0);
    checkOutput("miss counted", 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'd61100000000);
    waitRise(20, w, seen);
    checkValue("post-miss latency", w, 3);
    countHigh(1, 2000, w);
    checkValue("post-miss width", w, 500);
    checkOutput("post-miss count", 1'b0, 8'd2, 1'b0);
`endif

    $display("[TB] randomized runs");
    for (int ep = 0; ep < 4; ep++) begin
      basePos = 64'($urandom_range(0, 2000000000)) * 64'd10;
      doReset(basePos);
      tornPending = 0;
      offLeft = 0;
      for (int c = 0; c < 3000; c++) begin
        r = int'($urandom_range(0, 999));
        if (tornPending) begin
          position = basePos;
          tornPending = 0;
        end else if (r < 3) begin
          position = basePos ^ {32'($urandom), 32'($urandom)};
          tornPending = 1;
        end else if (r < 8) begin
          basePos += 64'($urandom_range(0, 400000000)) * 64'd10;
          position = basePos;
        end else if (r < 20) begin
          w = int'($urandom_range(0, 50000000));
          basePos = (basePos > 64'(w)) ? basePos - 64'(w) : 64'd0;
          position = basePos;
        end else if (r < 620) begin
          basePos += 64'($urandom_range(0, 60000000));
          position = basePos;
        end
        if (offLeft > 0) begin
          offLeft--;
          running = 1'b0;
        end else begin
          running = 1'b1;
          if ($urandom_range(0, 299) == 0) offLeft = int'($urandom_range(1, 50));
        end
        rst_n = ($urandom_range(0, 1999) != 0);
`ifdef STRIPE_MISS_EN
        miss_next = ($urandom_range(0, 99) == 0);
`endif
        tick();
        checkModel($sformatf("rand ep%0d cyc%0d", ep, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
